// File: rtl/rb_seq.sv
// rb_seq: operand-fetch / write-back sequencer, initiator side of the 16-bit
// CPU register bank. Takes one instruction at a time over valid/ready, selects
// the operand registers, latches the operands into the ALU, waits for the
// result and writes it back to rd.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   instr_valid/instr    instruction in: [15:12] opcode, [11:8] rd, [7:4] ra, [3:0] rb
//   instr_ready          high while the sequencer is idle
//   rs_out               register-bank select {rd, ra, rb}
//   rw_out, d_out        register-bank write strobe and write data
//   a_in, b_in           register-bank read data for ra / rb
//   alu_op, alu_a, alu_b opcode and latched operands towards the ALU
//   alu_start            one-cycle pulse in the first EXEC cycle
//   alu_done, alu_result ALU completion pulse and result
//   busy, halted         status (not idle / HALT executed)
//   err, err_clr         sticky ALU timeout flag and its clear
//   retire_cnt           completed write-backs, wrapping
//
// Build option
//   RB_SEQ_R0_ZERO_EN    when defined, R0 reads as zero and writes to R0 are
//                        dropped (write-back still retires).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for an instruction, instr_ready high
// READ  | operands from the bank are latched into alu_a / alu_b
// EXEC  | waiting for alu_done, bounded by TIMEOUT cycles
// WB    | rw_out high for one cycle, result written to rd
// HALT  | HALT executed, everything frozen until reset

module rb_seq #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [15:0]      instr,
  output logic             instr_ready,
  output logic [11:0]      rs_out,
  output logic             rw_out,
  output logic [15:0]      d_out,
  input  logic [15:0]      a_in,
  input  logic [15:0]      b_in,
  output logic [3:0]       alu_op,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [15:0]      alu_result,
  output logic             busy,
  output logic             halted,
  output logic             err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_HALT = 4'hF;
  // EXEC cycles are counted from 0, so the last allowed cycle is TIMEOUT-1.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  exec_cnt;
  logic        accept;
  logic        done_hit;
  logic        tmo_hit;
  logic        wr_en;
  logic [15:0] a_cap;
  logic [15:0] b_cap;

  assign instr_ready = (state == ST_IDLE);

`ifdef RB_SEQ_R0_ZERO_EN
  assign a_cap = (rs_out[7:4] == 4'd0) ? 16'h0000 : a_in;
  assign b_cap = (rs_out[3:0] == 4'd0) ? 16'h0000 : b_in;
  assign wr_en = done_hit && (rs_out[11:8] != 4'd0);
`else
  assign a_cap = a_in;
  assign b_cap = b_in;
  assign wr_en = done_hit;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done_hit  = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (instr_valid) begin
          accept    = 1'b1;
          state_nxt = (instr[15:12] == OP_HALT) ? ST_HALT : ST_READ;
        end
      end
      ST_READ: state_nxt = (alu_op == OP_NOP) ? ST_IDLE : ST_EXEC;
      ST_EXEC: begin
        // A result arriving on the last allowed cycle still counts.
        if (alu_done) begin
          done_hit  = 1'b1;
          state_nxt = ST_WB;
        end else if (exec_cnt == TMO_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_WB:   state_nxt = ST_IDLE;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_out     <= '0;
      rw_out     <= 1'b0;
      d_out      <= '0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_start  <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      err        <= 1'b0;
      retire_cnt <= '0;
      exec_cnt   <= '0;
    end else begin
      if (accept) begin
        alu_op <= instr[15:12];
        if (instr[15:12] != OP_HALT) rs_out <= instr[11:0];
      end
      if (state == ST_READ) begin
        alu_a <= a_cap;
        alu_b <= b_cap;
      end
      alu_start <= (state == ST_READ) && (alu_op != OP_NOP);
      exec_cnt  <= (state == ST_EXEC) ? exec_cnt + 8'd1 : 8'd0;
      if (done_hit) d_out <= alu_result;
      rw_out <= wr_en;
      if (state == ST_WB) retire_cnt <= retire_cnt + CNT_W'(1);
      if (tmo_hit)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
      busy   <= (state_nxt != ST_IDLE);
      halted <= (state_nxt == ST_HALT);
    end
  end

endmodule

// File: tb/tb_rb_seq.sv
module tb_rb_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [11:0] rs_out;
  logic        rw_out;
  logic [15:0] d_out;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic [3:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_start;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        busy;
  logic        halted;
  logic        err;
  logic        err_clr;
  logic [15:0] retire_cnt;

  always #5 clk = ~clk;

  rb_seq #(.TIMEOUT(15), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_ready(instr_ready),
    .rs_out     (rs_out),
    .rw_out     (rw_out),
    .d_out      (d_out),
    .a_in       (a_in),
    .b_in       (b_in),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .busy       (busy),
    .halted     (halted),
    .err        (err),
    .err_clr    (err_clr),
    .retire_cnt (retire_cnt)
  );

  // Register bank model: Rn starts at 0x1000 + n*0x11.
  logic [15:0] bank [16] = '{16'h1000, 16'h1011, 16'h1022, 16'h1033,
                             16'h1044, 16'h1055, 16'h1066, 16'h1077,
                             16'h1088, 16'h1099, 16'h10AA, 16'h10BB,
                             16'h10CC, 16'h10DD, 16'h10EE, 16'h10FF};
  assign a_in = bank[rs_out[7:4]];
  assign b_in = bank[rs_out[3:0]];
  always @(posedge clk) if (rw_out) bank[rs_out[11:8]] <= d_out;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] ins;
    int          lat;       // EXEC cycle carrying alu_done, 0 = never
    logic [15:0] res;
    logic [11:0] e_rs;
    logic [15:0] e_a;
    logic [15:0] e_b;
    logic [15:0] e_d;
    int          e_starts;
    int          e_writes;
    int          e_cycles;
    logic        e_err;
    logic [15:0] e_ret;
  } vec_t;

  vec_t vt[8];

  // Issue one instruction, play the ALU, and return when idle again.
  task automatic run_instr(input logic [15:0] ins, input int lat, input logic [15:0] res,
                           output int starts, output int writes, output int cycles);
    int k;
    bit fin;
    starts = 0; writes = 0; cycles = 0; k = 0; fin = 0;
    instr = ins;
    instr_valid = 1'b1;
    while (!fin) begin
      step();
      instr_valid = 1'b0;
      alu_done = 1'b0;
      cycles++;
      if (alu_start) begin
        starts++;
        k = 1;
      end else if (k > 0) begin
        k++;
      end
      if (rw_out) writes++;
      if (lat > 0 && k == lat) begin
        alu_done = 1'b1;
        alu_result = res;
      end
      if (instr_ready) fin = 1;
      if (cycles >= 100) begin
        total++;
        bad++;
        $display("FAIL run_bound: instr %0h still busy after %0d cycles", ins, cycles);
        fin = 1;
      end
    end
    alu_done = 1'b0;
  endtask

  initial begin
    int st, wr, cy, n;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    alu_done = 1'b0;
    alu_result = '0;
    err_clr = 1'b0;

`ifdef RB_SEQ_R0_ZERO_EN
    vt[5] = '{16'h1012, 2,  16'h1234, 12'h012, 16'h1011, 16'h00AA, 16'h1234, 1, 0, 5,  1'b0, 16'd4};
    vt[6] = '{16'h4301, 1,  16'h0001, 12'h301, 16'h0000, 16'h1011, 16'h0001, 1, 1, 4,  1'b0, 16'd5};
`else
    vt[5] = '{16'h1012, 2,  16'h1234, 12'h012, 16'h1011, 16'h00AA, 16'h1234, 1, 1, 5,  1'b0, 16'd4};
    vt[6] = '{16'h4301, 1,  16'h0001, 12'h301, 16'h1234, 16'h1011, 16'h0001, 1, 1, 4,  1'b0, 16'd5};
`endif
    vt[0] = '{16'h1213, 2,  16'h00AA, 12'h213, 16'h1011, 16'h1033, 16'h00AA, 1, 1, 5,  1'b0, 16'd1};
    vt[1] = '{16'h0456, 0,  16'h0000, 12'h456, 16'h1055, 16'h1066, 16'h00AA, 0, 0, 2,  1'b0, 16'd1};
    vt[2] = '{16'h3178, 0,  16'h0000, 12'h178, 16'h1077, 16'h1088, 16'h00AA, 1, 0, 17, 1'b1, 16'd1};
    vt[3] = '{16'h1512, 1,  16'h5555, 12'h512, 16'h1011, 16'h00AA, 16'h5555, 1, 1, 4,  1'b0, 16'd2};
    vt[4] = '{16'h2655, 3,  16'h0BAD, 12'h655, 16'h5555, 16'h5555, 16'h0BAD, 1, 1, 6,  1'b0, 16'd3};
    vt[7] = '{16'h5A9B, 15, 16'h7777, 12'hA9B, 16'h1099, 16'h10BB, 16'h7777, 1, 1, 18, 1'b0, 16'd6};

    step();
    step();
    chk("rst_ready",  instr_ready, 1);
    chk("rst_busy",   busy, 0);
    chk("rst_rs",     rs_out, 0);
    chk("rst_rw",     rw_out, 0);
    chk("rst_d",      d_out, 0);
    chk("rst_start",  alu_start, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err",    err, 0);
    chk("rst_retire", retire_cnt, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      run_instr(vt[i].ins, vt[i].lat, vt[i].res, st, wr, cy);
      chk($sformatf("v%0d_rs", i),     rs_out, vt[i].e_rs);
      chk($sformatf("v%0d_a", i),      alu_a, vt[i].e_a);
      chk($sformatf("v%0d_b", i),      alu_b, vt[i].e_b);
      chk($sformatf("v%0d_d", i),      d_out, vt[i].e_d);
      chk($sformatf("v%0d_starts", i), st, vt[i].e_starts);
      chk($sformatf("v%0d_writes", i), wr, vt[i].e_writes);
      chk($sformatf("v%0d_cycles", i), cy, vt[i].e_cycles);
      chk($sformatf("v%0d_err", i),    err, vt[i].e_err);
      chk($sformatf("v%0d_retire", i), retire_cnt, vt[i].e_ret);
      if (i == 2) begin
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("err_clr", err, 0);
      end
    end

    // alu_done while idle has no effect
    alu_done = 1'b1;
    alu_result = 16'hDEAD;
    step();
    alu_done = 1'b0;
    step();
    chk("stray_done_busy", busy, 0);
    chk("stray_done_rw", rw_out, 0);
    chk("stray_done_d", d_out, 16'h7777);
    chk("stray_done_retire", retire_cnt, 6);

    // HALT freezes the sequencer
    instr = 16'hF000;
    instr_valid = 1'b1;
    step();
    chk("halt_halted", halted, 1);
    chk("halt_ready", instr_ready, 0);
    chk("halt_rs", rs_out, 12'hA9B);
    instr = 16'h1111;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (alu_start || rw_out) n++;
    end
    instr_valid = 1'b0;
    chk("halt_activity", n, 0);
    chk("halt_hold", halted, 1);
    chk("halt_rs_hold", rs_out, 12'hA9B);
    chk("halt_retire", retire_cnt, 6);

    rst_n = 1'b0;
    #1;
    chk("unhalt_halted", halted, 0);
    chk("unhalt_ready", instr_ready, 1);
    chk("unhalt_retire", retire_cnt, 0);
    step();
    rst_n = 1'b1;
    step();

    // reset during write-back drops rw_out immediately
    instr = 16'h1213;
    instr_valid = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && !rw_out; c++) begin
      step();
      instr_valid = 1'b0;
      alu_done = alu_start;
      alu_result = 16'h0042;
      n = c + 1;
    end
    alu_done = 1'b0;
    chk("midrst_wb_reached", rw_out, 1);
    chk("midrst_wb_cycle", n, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rw", rw_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_d", d_out, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("midrst_retire", retire_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
